// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM control unit: opcode classes, data-processing
// commands, ALUControl/ImmSrc selects, condition codes and the sequencer state.
// No logic; imported by arm_cond_check and arm_control_unit.
package arm_ctrl_pkg;

  // Instr[27:26] instruction classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  // Data-processing cmd field Instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ImmSrc encodings
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Condition codes Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

endpackage

// File: rtl/arm_cond_check.sv
// NZCV flag register with condition evaluation and gated flag writes.
// Latency: cond_ex_o is combinational from the registered flags; flags_o updates one edge after a qualified write.
// Backpressure: none; writes happen only when commit_i and cond_ex_o are both high.
// Ports: clk_i/rst_i (async active-high), cond_i = Instr[31:28], alu_flags_i = {N,Z,C,V} from ALU,
//        flag_w_i = {update NZ, update CV}, commit_i = instruction retires this cycle,
//        cond_ex_o = condition passes, flags_o = registered NZCV.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       commit_i,
  output logic       cond_ex_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;
  assign flags_o      = flags_q;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = ~(n ^ v);
      COND_LT: cond_ex_o = n ^ v;
      COND_GT: cond_ex_o = ~z & ~(n ^ v);
      COND_LE: cond_ex_o = z | (n ^ v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;  // 1111 never executes
    endcase
  end

  // NZ and CV halves are written independently so logical ops keep C/V.
  always_comb begin
    flags_d = flags_q;
    if (commit_i && cond_ex_o) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM datapath: decode, condition gating, memory-wait/halt sequencer.
// Latency: strobes are combinational in the instruction's cycle; a stalled LDR/STR retires in the MemReady cycle.
// Backpressure: MemReady low holds PCWrite and all write enables low; after WAIT_LIMIT wait cycles the core faults into HALT.
// Ports: CLK, RESET (async active-high), Instr, ALUFlags {N,Z,C,V}, MemReady in; datapath strobes/selects,
//        PCWrite, MemReq, Flags (registered NZCV), Halted, Fault out.
module arm_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = 32'hEF000000,
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic        PCWrite,
  output logic        MemReq,
  output logic [3:0]  Flags,
  output logic        Halted,
  output logic        Fault
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign rd    = Instr[15:12];

  logic       reg_w, mem_w, branch, is_mem, is_halt, pcs;
  logic [1:0] flag_w;

  // ---------------- decoder ----------------
  always_comb begin
    ALUSrc     = 1'b0;
    ImmSrc     = IMM_DP;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    MemtoReg   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    is_mem     = 1'b0;
    is_halt    = 1'b0;
    flag_w     = 2'b00;
    case (op)
      OP_DP: begin
        ALUSrc = funct[5];
        // funct[0] is the S bit; only arithmetic commands touch C/V.
        case (cmd)
          CMD_ADD: begin ALUControl = ALU_ADD; reg_w = 1'b1; flag_w = {2{funct[0]}};   end
          CMD_SUB: begin ALUControl = ALU_SUB; reg_w = 1'b1; flag_w = {2{funct[0]}};   end
          CMD_AND: begin ALUControl = ALU_AND; reg_w = 1'b1; flag_w = {funct[0], 1'b0}; end
          CMD_ORR: begin ALUControl = ALU_ORR; reg_w = 1'b1; flag_w = {funct[0], 1'b0}; end
          CMD_CMP: begin ALUControl = ALU_SUB; reg_w = 1'b0; flag_w = {2{funct[0]}};   end
          default: ;  // undefined command: no write enables
        endcase
      end
      OP_MEM: begin
        ALUSrc = 1'b1;
        ImmSrc = IMM_MEM;
        is_mem = 1'b1;
        if (funct[0]) begin  // L bit: load
          MemtoReg = 1'b1;
          reg_w    = 1'b1;
        end else begin
          mem_w  = 1'b1;
          RegSrc = 2'b10;
        end
      end
      OP_BR: begin
        ImmSrc = IMM_BR;
        ALUSrc = 1'b1;
        RegSrc = 2'b01;
        branch = 1'b1;
      end
      default: is_halt = (Instr == HALT_INSTR);
    endcase
  end

  // A register write to R15 is also a PC redirect.
  assign pcs = branch | ((rd == 4'd15) & reg_w);

  // ---------------- condition / flags ----------------
  logic cond_ex, commit;

  arm_cond_check u_cond (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .cond_i      (Instr[31:28]),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .commit_i    (commit),
    .cond_ex_o   (cond_ex),
    .flags_o     (Flags)
  );

  // ---------------- sequencer ----------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             pc_write, mem_req;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    commit   = 1'b0;
    pc_write = 1'b0;
    mem_req  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_mem && cond_ex) begin
          mem_req = 1'b1;
          if (MemReady) begin
            commit   = 1'b1;
            pc_write = 1'b1;
          end else begin
            state_d = ST_MEMWAIT;
            cnt_d   = CNT_W'(1);
          end
        end else if (is_halt && cond_ex) begin
          state_d = ST_HALT;
        end else begin
          // includes condition-failed instructions: PC advances, enables gated by cond_ex
          commit   = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        mem_req = 1'b1;
        if (MemReady) begin  // completion wins over the timeout in the same cycle
          commit   = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_RUN;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_W'(WAIT_LIMIT)) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
    // The state register already sits at RUN while RESET is high; keep
    // RUN's default PC advance and any commit from leaking out.
    if (RESET) begin
      commit   = 1'b0;
      pc_write = 1'b0;
      mem_req  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign RegWrite = reg_w & cond_ex & commit;
  assign MemWrite = mem_w & cond_ex & commit;
  assign PCSrc    = pcs   & cond_ex & commit;
  assign PCWrite  = pc_write;
  assign MemReq   = mem_req;
  assign Halted   = (state_q == ST_HALT);
  assign Fault    = fault_q;

endmodule
